cache_refill_arbiter: RTL and testbench

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/cache_refill_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_refill_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory path: refill FSM states,
// refill owner encoding and the default burst length.
package cpu_mem_pkg;

  localparam int unsigned DEFAULT_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/cache_refill_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto a single
// burst memory port, round-robin on ties, one-cycle done pulse per burst.
module cache_refill_arbiter
  import cpu_mem_pkg::*;
#(
  parameter  int unsigned BURST_LEN = DEFAULT_BURST_LEN,
  localparam int unsigned BW        = $clog2(BURST_LEN),
  localparam int unsigned LW        = 30 - BW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ic_req,
  input  logic [31:0]   ic_addr,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [31:0]   dc_addr,
  input  logic [31:0]   dc_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic [BW-1:0] beat,
  output logic [31:0]   rdata,
  output logic          ic_rvalid,
  output logic          dc_rvalid,
  output logic          ic_done,
  output logic          dc_done,
  output logic          cache_stall
);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] line_q, line_d;
  logic          armed_q, armed_d;
  logic          wr_burst;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{ic_addr[1+BW:0], dc_addr[1+BW:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      beat_q  <= '0;
      line_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      armed_q <= armed_d;
    end
  end

  // armed_q keeps the FSM frozen on the first edge after reset release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    line_d  = line_q;
    armed_d = 1'b1;
    if (armed_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ic_req || dc_req) begin
            owner_d = (dc_req && (!ic_req || owner_q == OWN_I)) ? OWN_D : OWN_I;
            line_d  = (owner_d == OWN_D) ? dc_addr[31:2+BW] : ic_addr[31:2+BW];
            beat_d  = '0;
            state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          if (mem_ready) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == BW'(BURST_LEN - 1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign wr_burst = (owner_q == OWN_D) && dc_we;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ic_rvalid = 1'b0;
    dc_rvalid = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    case (state_q)
      ST_BURST: begin
        mem_req = 1'b1;
        mem_we  = wr_burst;
        if (mem_ready && !wr_burst) begin
          ic_rvalid = (owner_q == OWN_I);
          dc_rvalid = (owner_q == OWN_D);
        end
      end
      ST_DONE: begin
        ic_done = (owner_q == OWN_I);
        dc_done = (owner_q == OWN_D);
      end
      default: ;
    endcase
  end

  assign mem_addr    = {line_q, beat_q, 2'b00};
  assign mem_wdata   = dc_wdata;
  assign rdata       = mem_rdata;
  assign beat        = beat_q;
  assign cache_stall = ic_req | dc_req | (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: per-cycle vector table on a
// 4-beat instance, plus round-robin and 8-beat sequences.
module tb_cache_refill_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;

  logic        mem_req, mem_we, ic_rvalid, dc_rvalid, ic_done, dc_done, cache_stall;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  beat;

  logic        mem_req8, mem_we8, ic_rvalid8, dc_rvalid8, ic_done8, dc_done8, cache_stall8;
  logic [31:0] mem_addr8, mem_wdata8, rdata8;
  logic [2:0]  beat8;

  always #5 clock = ~clock;

  cache_refill_arbiter #(.BURST_LEN(4)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .beat(beat), .rdata(rdata),
    .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .ic_done(ic_done), .dc_done(dc_done), .cache_stall(cache_stall)
  );

  cache_refill_arbiter #(.BURST_LEN(8)) dut8 (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .beat(beat8), .rdata(rdata8),
    .ic_rvalid(ic_rvalid8), .dc_rvalid(dc_rvalid8),
    .ic_done(ic_done8), .dc_done(dc_done8), .cache_stall(cache_stall8)
  );

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, wd;
    logic        rdy;
    logic [31:0] rd;
    logic        mreq, mwe;
    logic [31:0] maddr;
    logic [2:0]  bt;
    logic        irv, drv, idone, ddone, stall;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] wd,
    input logic rdy, input logic [31:0] rd,
    input logic mreq, input logic mwe, input logic [31:0] maddr, input logic [2:0] bt,
    input logic irv, input logic drv, input logic idone, input logic ddone, input logic stall);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.wd = wd;
    v.rdy = rdy; v.rd = rd; v.mreq = mreq; v.mwe = mwe; v.maddr = maddr; v.bt = bt;
    v.irv = irv; v.drv = drv; v.idone = idone; v.ddone = ddone; v.stall = stall;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int    got[$];
    int    nic, ndc;
    logic  drop_i, drop_d, raised2, seen;
    string nm;

    // Single I refill, including reset state and the held first edge.
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,32'h0, 0,32'h0,    0,0,32'h0,   0,0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'h0,    0,0,32'h0,   0,0,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'h0,    0,0,32'h0,   0,0,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'hA0A0, 1,0,32'h1230,0,1,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'hA1A1, 1,0,32'h1234,1,1,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'hA2A2, 1,0,32'h1238,2,1,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'hA3A3, 1,0,32'h123C,3,1,0,0,0,1));
    tbl.push_back(mk(1,1,32'h1234,0,0,32'h0,32'h0, 1,32'h0,    0,0,32'h0,   0,0,0,1,0,1));
    tbl.push_back(mk(1,0,32'h0,   0,0,32'h0,32'h0, 0,32'h0,    0,0,32'h0,   0,0,0,0,0,0));
    // D writeback with mem_ready toggling.
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB0, 0,32'h0, 0,0,32'h0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB0, 1,32'h0, 1,1,32'h80,0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB1, 0,32'h0, 1,1,32'h84,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB1, 1,32'h0, 1,1,32'h84,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB2, 0,32'h0, 1,1,32'h88,2,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB2, 1,32'h0, 1,1,32'h88,2,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB3, 0,32'h0, 1,1,32'h8C,3,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'hB3, 1,32'h0, 1,1,32'h8C,3,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h80,32'h0,  1,32'h0, 0,0,32'h0, 0,0,0,0,1,1));
    tbl.push_back(mk(1,0,32'h0,0,0,32'h0, 32'h0,  0,32'h0, 0,0,32'h0, 0,0,0,0,0,0));
    // I request withdrawn mid-burst.
    tbl.push_back(mk(1,1,32'h2000,0,0,32'h0,32'h0, 0,32'h0,  0,0,32'h0,   0,0,0,0,0,1));
    tbl.push_back(mk(1,1,32'h2000,0,0,32'h0,32'h0, 1,32'hD0, 1,0,32'h2000,0,1,0,0,0,1));
    tbl.push_back(mk(1,0,32'h2000,0,0,32'h0,32'h0, 1,32'hD1, 1,0,32'h2004,1,1,0,0,0,1));
    tbl.push_back(mk(1,0,32'h2000,0,0,32'h0,32'h0, 1,32'hD2, 1,0,32'h2008,2,1,0,0,0,1));
    tbl.push_back(mk(1,0,32'h2000,0,0,32'h0,32'h0, 1,32'hD3, 1,0,32'h200C,3,1,0,0,0,1));
    tbl.push_back(mk(1,0,32'h2000,0,0,32'h0,32'h0, 0,32'h0,  0,0,32'h0,   0,0,0,1,0,1));
    tbl.push_back(mk(1,0,32'h0,   0,0,32'h0,32'h0, 0,32'h0,  0,0,32'h0,   0,0,0,0,0,0));
    // D refill, reset at beat 2, then re-request restarts at beat 0.
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 0,32'h0,  0,0,32'h0,  0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE0, 1,0,32'h400,0,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE1, 1,0,32'h404,1,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 0,32'h0,  1,0,32'h408,2,0,0,0,0,1));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h400,32'h0, 1,32'h0,  0,0,32'h0,  0,0,0,0,0,1));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h400,32'h0, 1,32'h0,  0,0,32'h0,  0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'h0,  0,0,32'h0,  0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'h0,  0,0,32'h0,  0,0,0,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE0, 1,0,32'h400,0,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE1, 1,0,32'h404,1,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE2, 1,0,32'h408,2,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 1,32'hE3, 1,0,32'h40C,3,0,1,0,0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h400,32'h0, 0,32'h0,  0,0,32'h0,  0,0,0,0,1,1));
    tbl.push_back(mk(1,0,32'h0,0,0,32'h0,  32'h0, 0,32'h0,  0,0,32'h0,  0,0,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].rst; ic_req = tbl[i].ir; ic_addr = tbl[i].ia;
      dc_req = tbl[i].dr; dc_we = tbl[i].dwe; dc_addr = tbl[i].da; dc_wdata = tbl[i].wd;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
      #1;
      nm = $sformatf("row%0d", i);
      chk({nm, " mem_req"},     32'(mem_req),     32'(tbl[i].mreq));
      chk({nm, " mem_we"},      32'(mem_we),      32'(tbl[i].mwe));
      chk({nm, " beat"},        32'(beat),        32'(tbl[i].bt));
      chk({nm, " ic_rvalid"},   32'(ic_rvalid),   32'(tbl[i].irv));
      chk({nm, " dc_rvalid"},   32'(dc_rvalid),   32'(tbl[i].drv));
      chk({nm, " ic_done"},     32'(ic_done),     32'(tbl[i].idone));
      chk({nm, " dc_done"},     32'(dc_done),     32'(tbl[i].ddone));
      chk({nm, " cache_stall"}, 32'(cache_stall), 32'(tbl[i].stall));
      if (tbl[i].mreq) chk({nm, " mem_addr"}, mem_addr, tbl[i].maddr);
      if (tbl[i].mwe)  chk({nm, " mem_wdata"}, mem_wdata, tbl[i].wd);
      if (tbl[i].irv || tbl[i].drv) chk({nm, " rdata"}, rdata, tbl[i].rd);
    end

    // Round robin: ties after reset go D then I; a second tie repeats D, I.
    @(negedge clock);
    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; ic_req = 1'b1; dc_req = 1'b1;
    ic_addr = 32'h3000; dc_addr = 32'h5000; mem_ready = 1'b1;
    nic = 0; ndc = 0; drop_i = 1'b0; drop_d = 1'b0; raised2 = 1'b0;
    for (int c = 0; c < 120 && got.size() < 4; c++) begin
      if (c != 0) begin
        @(negedge clock);
        if (got.size() == 2 && !ic_req && !dc_req && !raised2) begin
          ic_req = 1'b1; dc_req = 1'b1; raised2 = 1'b1;
        end
        if (drop_i) ic_req = 1'b0;
        if (drop_d) dc_req = 1'b0;
        drop_i = 1'b0; drop_d = 1'b0;
      end
      #1;
      if (ic_rvalid) nic++;
      if (dc_rvalid) ndc++;
      if (ic_done) begin got.push_back(0); drop_i = 1'b1; end
      if (dc_done) begin got.push_back(1); drop_d = 1'b1; end
    end
    chk("rr done count", 32'(got.size()), 32'd4);
    while (got.size() < 4) got.push_back(-1);
    chk("rr grant0 is D", 32'(got[0]), 32'd1);
    chk("rr grant1 is I", 32'(got[1]), 32'd0);
    chk("rr grant2 is D", 32'(got[2]), 32'd1);
    chk("rr grant3 is I", 32'(got[3]), 32'd0);
    chk("rr ic_rvalid beats", 32'(nic), 32'd8);
    chk("rr dc_rvalid beats", 32'(ndc), 32'd8);

    // 8-beat instance: line wraps inside 32 bytes, beat wraps 7 -> 0.
    @(negedge clock);
    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clock);
    reset = 1'b1; ic_req = 1'b1; ic_addr = 32'h1234; mem_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clock);
      #1;
      seen = mem_req8;
    end
    chk("b8 grant seen", 32'(seen), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b8 addr k%0d", k), mem_addr8, 32'h1220 + 32'(4 * k));
      chk($sformatf("b8 beat k%0d", k), 32'(beat8), 32'(k));
      chk($sformatf("b8 rvalid k%0d", k), 32'(ic_rvalid8), 32'd1);
      @(negedge clock);
      #1;
    end
    chk("b8 ic_done", 32'(ic_done8), 32'd1);
    chk("b8 beat wrapped", 32'(beat8), 32'd0);
    chk("b8 mem_req low in done", 32'(mem_req8), 32'd0);
    @(negedge clock);
    ic_req = 1'b0;
    #1;
    chk("b8 done single cycle", 32'(ic_done8), 32'd0);
    chk("b8 idle mem_req", 32'(mem_req8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
